pwm_gen: RTL
============

// Module: pwm_gen
// PURPOSE
//  Parametrised PWM generator for the synth audio output path. Converts an
//  unsigned WIDTH-bit sample into a pulse-width-modulated 1-bit output.
//  Supports edge- or centre-aligned modes, a clock prescaler and a
//  double-buffered sample input with valid/ready handshake. The duty cycle
//  only ever changes at a period boundary, so output pulses are never torn.
// PARAMETERS
//  WIDTH   8  sample/counter width; edge-mode period = 2^WIDTH ticks
//  DIV_W   8  prescaler divide-value width
// PORTS
//  clk           in   1      system clock, rising edge
//  n_rst         in   1      async active-low reset
//  en            in   1      run enable
//  mode          in   1      0 = edge-aligned, 1 = centre-aligned
//  div           in   DIV_W  tick every div+1 clocks
//  sample        in   WIDTH  unsigned duty value
//  sample_valid  in   1      sample present
//  sample_ready  out  1      shadow buffer empty, can accept a sample
//  pwm_o         out  1      PWM output, registered
//  period_start  out  1      1-clk pulse at each period boundary
// BEHAVIOUR
//  Interface:
//   - One clock (clk). Reset n_rst is asynchronous, active-low.
//  Reset values:
//   - pwm_o = 0, period_start = 0, sample_ready = 1.
//   - Internal: duty = 0, shadow empty, cnt = 0, dir = UP, div_cnt = 0,
//     mode_q = 0.
//  Prescaler:
//   - tick = en & (div_cnt >= div).
//   - On tick, div_cnt <= 0; otherwise div_cnt++.
//   - div is live. Lowering div below div_cnt gives a tick on the next clock.
//  Edge mode (mode_q = 0):
//   - On each tick cnt advances 0..2^WIDTH-1, then wraps to 0.
//   - The boundary is the tick on which cnt = 2^WIDTH-1.
//  Centre mode (mode_q = 1):
//   - Up/down counter. dir UP: cnt++ until MAX = 2^WIDTH-1, then dir = DN.
//   - dir DN: cnt-- down to 1; the next tick sets cnt = 0 and dir = UP.
//   - The boundary is the tick on which dir = DN and cnt = 1.
//   - Period = 2*MAX ticks.
//  Boundary actions (same edge):
//   - cnt <= 0, dir <= UP, mode_q <= mode, period_start <= 1.
//   - If the shadow is full: duty <= shadow and the shadow is cleared.
//   - Otherwise duty is unchanged, so the last sample repeats.
//  Output:
//   - pwm_o <= en & (cnt < duty), so pwm_o lags cnt by one clock.
//   - Edge mode: high ticks per period = duty.
//   - Centre mode: high ticks per period = 0 if duty = 0, else 2*duty-1.
//  Handshake:
//   - sample_ready = !shadow_full, driven from a register.
//   - When valid & ready, sample is written to the shadow, which becomes full.
//   - Boundary and handshake in the same cycle: the shadow (empty) captures
//     the sample, duty is not updated, and the new value loads at the next
//     boundary.
//   - A valid held while ready = 0 is not consumed; the source must hold
//     sample stable.
//  en low:
//   - div_cnt, cnt, dir and pwm_o are held at reset values.
//   - period_start = 0 and mode_q <= mode.
//   - If the shadow is full, duty <= shadow and the shadow is cleared every
//     clock. The first period after en rises therefore uses the latest sample.
//  en rising:
//   - Counting starts from cnt = 0 on the same clock.
//  Reset mid-operation:
//   - All state returns to reset values immediately; any pending shadow
//     sample is discarded.
// TESTING
//  1. W=8, div=0, edge, push 64 while en=0, then en=1:
//     pwm_o 64 clk high / 192 low; period_start every 256 clk.
//  2. Edge mode, duty=0: pwm_o never high.
//     Edge mode, duty=255: 255 high / 1 low per period.
//  3. Centre mode, div=0, duty=10:
//     19 high clk per 510-clk period, symmetric about period_start.
//  4. div=3, edge, duty=128:
//     512 clk high per 1024-clk period. Change div to 0 mid-tick: next clk ticks.
//  5. Push A=32 mid-period: ready drops; B=200 stalls (valid=1, ready=0).
//     At the boundary duty=A and ready rises the next clk; B is accepted.
//     At the following boundary duty=B.
//  6. Pull n_rst low mid-period with the shadow full:
//     pwm_o=0, ready=1 asynchronously. After release, with no push, pwm_o stays 0.

Source files
------------

// File: rtl/pwm_gen.sv
// PWM generator for the synth audio path: edge/centre-aligned counter with prescaler
// and a double-buffered duty sample that only takes effect at a period boundary.
module pwm_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             mode,
    input  logic [DIV_W-1:0] div,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_o,
    output logic             period_start
);

    localparam logic [WIDTH-1:0] MAX = '1;

    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_t;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    dir_t             dir_q, dir_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             shadow_full_q, shadow_full_d;
    logic             ready_q, ready_d;
    logic             pwm_q, pwm_d;
    logic             period_start_q, period_start_d;

    logic tick;
    logic boundary;
    logic accept;

    always_comb begin
        tick     = en && (div_cnt_q >= div);
        boundary = tick && (mode_q ? (dir_q == DN && cnt_q == WIDTH'(1))
                                   : (cnt_q == MAX));
        accept   = sample_valid && ready_q;

        div_cnt_d      = div_cnt_q;
        cnt_d          = cnt_q;
        dir_d          = dir_q;
        mode_d         = mode_q;
        duty_d         = duty_q;
        shadow_d       = shadow_q;
        shadow_full_d  = shadow_full_q;
        pwm_d          = 1'b0;
        period_start_d = 1'b0;

        if (!en) begin
            // Idle: keep the counter parked and let the latest sample through
            // immediately so the first period after enable uses it.
            div_cnt_d = '0;
            cnt_d     = '0;
            dir_d     = UP;
            mode_d    = mode;
            if (shadow_full_q) begin
                duty_d        = shadow_q;
                shadow_full_d = 1'b0;
            end
        end else begin
            pwm_d     = (cnt_q < duty_q);
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            if (boundary) begin
                cnt_d          = '0;
                dir_d          = UP;
                mode_d         = mode;
                period_start_d = 1'b1;
                if (shadow_full_q) begin
                    duty_d        = shadow_q;
                    shadow_full_d = 1'b0;
                end
            end else if (tick) begin
                if (!mode_q) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (dir_q == UP) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == MAX - 1'b1) begin
                        dir_d = DN;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end

        // Ready is only high while the shadow is empty, so a capture never
        // collides with a boundary load in the same cycle.
        if (accept) begin
            shadow_d      = sample;
            shadow_full_d = 1'b1;
        end
        ready_d = !shadow_full_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_cnt_q      <= '0;
            cnt_q          <= '0;
            dir_q          <= UP;
            mode_q         <= 1'b0;
            duty_q         <= '0;
            shadow_q       <= '0;
            shadow_full_q  <= 1'b0;
            ready_q        <= 1'b1;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            mode_q         <= mode_d;
            duty_q         <= duty_d;
            shadow_q       <= shadow_d;
            shadow_full_q  <= shadow_full_d;
            ready_q        <= ready_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign sample_ready = ready_q;
    assign pwm_o        = pwm_q;
    assign period_start = period_start_q;

endmodule
